// File: rtl/rr_selector_arbiter_8_32_pkg.sv
// Shared constants and state type for the round-robin selector arbiter.
package sel_arb_pkg;
   localparam int N_DEF  = 8;
   localparam int DW_DEF = 32;
   localparam int SW_DEF = $clog2(N_DEF);

   typedef enum logic {IDLE, BUSY} arb_state_t;
endpackage

// File: rtl/rr_selector_arbiter_8_32_if.sv
// Requester and downstream signal bundle for the round-robin selector arbiter.
interface rr_selector_arbiter_8_32_if
   import sel_arb_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int DW = DW_DEF
);
   localparam int SW = $clog2(N);

   logic              en;
   logic [N-1:0]      req;
   logic [DW-1:0]     x [N-1:0];
   logic [N-1:0]      gnt;
   logic [SW-1:0]     s;
   logic [DW-1:0]     y;
   logic              y_valid;
   logic              y_ready;
   logic [N-1:0]      ack;

   modport master (
      input  en, req, x, y_ready,
      output gnt, s, y, y_valid, ack
   );

   modport slave (
      output en, req, x, y_ready,
      input  gnt, s, y, y_valid, ack
   );
endinterface

// File: rtl/rr_selector_arbiter_8_32_pick.sv
// Round-robin pick: first set request after i_ptr, searching upward with wrap.
module rr_priority_pick
   import sel_arb_pkg::*;
#(
   parameter  int N  = N_DEF,
   localparam int SW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [SW-1:0] i_ptr,
   output logic          o_any,
   output logic [SW-1:0] o_win
);
   logic [2*N-1:0] w_dbl;
   logic [N-1:0]   w_rot;
   logic [SW:0]    w_sh;
   logic [SW-1:0]  w_off;

   // Rotating so index ptr+1 lands at bit 0 turns round-robin into lowest-bit-first.
   assign w_dbl = {i_req, i_req};
   assign w_sh  = {1'b0, i_ptr} + (SW+1)'(1);
   assign w_rot = w_dbl[w_sh +: N];

   always_comb begin
      w_off = '0;
      for (int unsigned i = N; i > 0; i--) begin
         if (w_rot[i-1]) w_off = SW'(i-1);
      end
   end

   assign o_any = |i_req;
   assign o_win = i_ptr + SW'(1) + w_off;
endmodule

// File: rtl/rr_selector_arbiter_8_32.sv
// Round-robin arbiter sharing one N:1 x DW selector; registered output with valid/ready.
module rr_selector_arbiter_8_32
   import sel_arb_pkg::*;
#(
   parameter  int N  = N_DEF,
   parameter  int DW = DW_DEF,
   localparam int SW = $clog2(N)
) (
   input logic                        clk,
   input logic                        rst_n,
   rr_selector_arbiter_8_32_if.master bus
);
   arb_state_t    r_state, w_state_nxt;
   logic [SW-1:0] r_ptr, r_s, w_win, w_pick_ptr;
   logic [N-1:0]  r_gnt, w_cand;
   logic [DW-1:0] r_y, w_sel;
   logic          w_any, w_hs, w_load;

   assign w_hs = (r_state == BUSY) & bus.y_ready;

   // While busy the current owner is masked and the search starts just past it.
   always_comb begin
      w_cand     = bus.req;
      w_pick_ptr = r_ptr;
      if (r_state == BUSY) begin
         w_cand     = bus.req & ~r_gnt;
         w_pick_ptr = r_s;
      end
   end

   rr_priority_pick #(.N(N)) u_pick (
      .i_req (w_cand),
      .i_ptr (w_pick_ptr),
      .o_any (w_any),
      .o_win (w_win)
   );

   assign w_load = bus.en & w_any & ((r_state == IDLE) | w_hs);

   always_comb begin
      w_sel = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (w_win == SW'(i)) w_sel = bus.x[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_load) w_state_nxt = BUSY;
         BUSY:    if (w_hs && !w_load) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.gnt     = r_gnt;
      bus.s       = r_s;
      bus.y       = r_y;
      bus.y_valid = (r_state == BUSY);
      bus.ack     = r_gnt & {N{w_hs}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= SW'(N-1);
         r_s   <= '0;
         r_gnt <= '0;
         r_y   <= '0;
      end else begin
         if (w_hs) r_ptr <= r_s;
         if (w_load) begin
            r_s   <= w_win;
            r_gnt <= N'(1) << w_win;
            r_y   <= w_sel;
         end else if (w_hs) begin
            r_gnt <= '0;
         end
      end
   end

   a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_gnt));
   a_valid:  assert property (@(posedge clk) disable iff (!rst_n) (r_state == BUSY) == (|r_gnt));
   a_sel:    assert property (@(posedge clk) disable iff (!rst_n)
                (r_state == BUSY) |-> (r_gnt == (N'(1) << r_s)));
   a_hold:   assert property (@(posedge clk) disable iff (!rst_n)
                (r_state == BUSY && !bus.y_ready) |=> ($stable(r_gnt) && $stable(r_s) && $stable(r_y)));
   a_req:    assert property (@(posedge clk) disable iff (!rst_n)
                (r_state == BUSY) |-> (|(bus.req & r_gnt)));
endmodule
